zero_byte_scanner: RTL and testbench

ZERO_BYTE_SCANNER -- requirements
Module: zero_byte_scanner

---
 rtl/zero_byte_scanner_if.sv | 28 ++
 rtl/zero_byte_scanner.sv | 143 ++++++++++++++
 tb/tb_zero_byte_scanner.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/zero_byte_scanner_if.sv
// Handshake and result bundle for zero_byte_scanner: the scan request, the
// input word stream and the result channel.
interface zero_byte_scanner_if #(
  parameter int NBYTES = 4,
  parameter int CNT_W  = 16
);
  logic                  start;
  logic [7:0]            match_byte;
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      out_len;
  logic                  out_found;
  logic                  out_ovf;
  logic                  busy;

  modport master (
    output start, match_byte, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_len, out_found, out_ovf, busy
  );

  modport slave (
    input  start, match_byte, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_len, out_found, out_ovf, busy
  );
endinterface

// File: rtl/zero_byte_scanner.sv
// Scans a word stream for the first occurrence of a byte and reports how many
// stream bytes precede it, saturating the count at the counter width.
module zero_byte_scanner #(
  parameter int NBYTES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  zero_byte_scanner_if.slave  bus
);

  localparam int              IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W:0]  STEP    = (CNT_W+1)'(NBYTES);
  localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [7:0]         match_r;
  logic [7:0]         match_nxt_s;
  logic [CNT_W-1:0]   out_len_r;
  logic [CNT_W-1:0]   len_nxt_s;
  logic               found_r;
  logic               found_nxt_s;
  logic               ovf_r;
  logic               ovf_nxt_s;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               busy_r;
  logic               hit_s;
  logic [IDX_W-1:0]   idx_s;
  logic [CNT_W:0]     match_sum_s;
  logic [CNT_W:0]     step_sum_s;

  // Priority encoder: walking from the top byte down leaves the lowest match index.
  always_comb begin
    hit_s = 1'b0;
    idx_s = {IDX_W{1'b0}};
    for (int k = NBYTES - 1; k >= 0; k--) begin
      idx_s = (bus.in_data[8*k +: 8] == match_r) ? IDX_W'(k) : idx_s;
      hit_s = hit_s | (bus.in_data[8*k +: 8] == match_r);
    end
  end

  // One extra bit on both sums exposes saturation as the carry-out.
  assign match_sum_s = {1'b0, count_r} + (CNT_W+1)'(idx_s);
  assign step_sum_s  = {1'b0, count_r} + STEP;

  // Next-state and next-result logic.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    match_nxt_s = match_r;
    len_nxt_s   = out_len_r;
    found_nxt_s = found_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          match_nxt_s = bus.match_byte;
          count_nxt_s = {CNT_W{1'b0}};
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (bus.in_valid && hit_s) begin
          found_nxt_s = 1'b1;
          ovf_nxt_s   = match_sum_s[CNT_W];
          len_nxt_s   = match_sum_s[CNT_W] ? LEN_MAX : match_sum_s[CNT_W-1:0];
          state_nxt_s = DONE;
        end else if (bus.in_valid && !step_sum_s[CNT_W]) begin
          count_nxt_s = step_sum_s[CNT_W-1:0];
        end else if (bus.in_valid) begin
          found_nxt_s = 1'b0;
          ovf_nxt_s   = 1'b1;
          len_nxt_s   = LEN_MAX;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= {CNT_W{1'b0}};
      match_r     <= 8'h00;
      out_len_r   <= {CNT_W{1'b0}};
      found_r     <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      match_r     <= match_nxt_s;
      out_len_r   <= len_nxt_s;
      found_r     <= found_nxt_s;
      ovf_r       <= ovf_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      in_ready_r  <= (state_nxt_s == SCAN);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_len   = out_len_r;
  assign bus.out_found = found_r;
  assign bus.out_ovf   = ovf_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_zero_byte_scanner.sv
// Self-checking bench: two scanners (16-bit and 4-bit counters) share one
// stimulus stream and are compared against a stream-level reference model.
module tb_zero_byte_scanner;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  zero_byte_scanner_if #(.NBYTES(4), .CNT_W(16)) a ();
  zero_byte_scanner_if #(.NBYTES(4), .CNT_W(4))  b ();

  assign b.start      = a.start;
  assign b.match_byte = a.match_byte;
  assign b.in_valid   = a.in_valid;
  assign b.in_data    = a.in_data;
  assign b.out_ready  = a.out_ready;

  zero_byte_scanner #(.NBYTES(4), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(a));
  zero_byte_scanner #(.NBYTES(4), .CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream-level model: first matching byte position; the scan gives up on
  // the first beat whose end would push the byte count past the counter range.
  function automatic void ref_scan(input logic [7:0] mb, input logic [7:0] strm[$],
                                   input int nb, input int cntw,
                                   output longint len, output bit found,
                                   output bit ovf, output int term_beat);
    longint maxv;
    longint limit_b;
    longint p;
    maxv    = (64'd1 << cntw) - 64'd1;
    limit_b = maxv / nb;
    found   = 1'b0;
    p       = 0;
    for (int i = 0; i < strm.size(); i++) begin
      if (!found && (i / nb) <= limit_b && strm[i] == mb) begin
        found = 1'b1;
        p     = i;
      end
    end
    if (found) begin
      term_beat = int'(p / nb);
      ovf       = (p > maxv);
      len       = ovf ? maxv : p;
    end else begin
      term_beat = (strm.size() >= (limit_b + 1) * nb) ? int'(limit_b) : -1;
      ovf       = 1'b1;
      len       = maxv;
    end
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_len16"},   32'(a.out_len),   32'd0);
    chk({tag, "_found16"}, 32'(a.out_found), 32'd0);
    chk({tag, "_ovf16"},   32'(a.out_ovf),   32'd0);
    chk({tag, "_valid16"}, 32'(a.out_valid), 32'd0);
    chk({tag, "_ready16"}, 32'(a.in_ready),  32'd0);
    chk({tag, "_busy16"},  32'(a.busy),      32'd0);
    chk({tag, "_valid4"},  32'(b.out_valid), 32'd0);
    chk({tag, "_busy4"},   32'(b.busy),      32'd0);
  endtask

  task automatic run_scan(input logic [7:0] mb, input logic [31:0] beats[$],
                          input bit gaps, input int hold);
    logic [7:0] strm[$];
    longint     len16, len4;
    bit         f16, o16, f4, o4;
    int         t16, t4;
    for (int i = 0; i < beats.size(); i++) begin
      for (int k = 0; k < 4; k++) strm.push_back(beats[i][8*k +: 8]);
    end
    ref_scan(mb, strm, 4, 16, len16, f16, o16, t16);
    ref_scan(mb, strm, 4, 4, len4, f4, o4, t4);
    chk("stim_terminates", 32'(t16 >= 0), 32'd1);
    if (t16 >= 0) begin
      a.start      = 1'b1;
      a.match_byte = mb;
      tick();
      a.start      = 1'b0;
      a.match_byte = 8'($urandom);
      chk("scan_busy", 32'(a.busy), 32'd1);
      chk("scan_ready", 32'(a.in_ready), 32'd1);
      for (int bt = 0; bt <= t16; bt++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            tick();
            chk("idle_ready", 32'(a.in_ready), 32'd1);
            chk("idle_valid", 32'(a.out_valid), 32'd0);
          end
        end
        a.in_valid = 1'b1;
        a.in_data  = beats[bt];
        tick();
        a.in_valid = 1'b0;
        a.in_data  = $urandom;
        if (bt < t16) begin
          chk("mid_valid", 32'(a.out_valid), 32'd0);
        end else begin
          chk("res_valid", 32'(a.out_valid), 32'd1);
          chk("res_len",   32'(a.out_len),   32'(len16));
          chk("res_found", 32'(a.out_found), 32'(f16));
          chk("res_ovf",   32'(a.out_ovf),   32'(o16));
          chk("res_ready", 32'(a.in_ready),  32'd0);
        end
      end
      repeat (hold) begin
        tick();
        chk("hold_valid", 32'(a.out_valid), 32'd1);
        chk("hold_len",   32'(a.out_len),   32'(len16));
        chk("hold_found", 32'(a.out_found), 32'(f16));
        chk("hold_ovf",   32'(a.out_ovf),   32'(o16));
        chk("hold_ready", 32'(a.in_ready),  32'd0);
      end
      chk("w4_valid", 32'(b.out_valid), 32'd1);
      chk("w4_len",   32'(b.out_len),   32'(len4));
      chk("w4_found", 32'(b.out_found), 32'(f4));
      chk("w4_ovf",   32'(b.out_ovf),   32'(o4));
      // Release the result with a start in the same cycle; that start must be dropped.
      a.out_ready = 1'b1;
      a.start     = 1'b1;
      tick();
      a.out_ready = 1'b0;
      a.start     = 1'b0;
      chk("rel_valid16", 32'(a.out_valid), 32'd0);
      chk("rel_busy16",  32'(a.busy),      32'd0);
      chk("rel_valid4",  32'(b.out_valid), 32'd0);
      tick();
      chk("drop_start16", 32'(a.busy), 32'd0);
      chk("drop_start4",  32'(b.busy), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] beats[$];
    logic [31:0] w;
    logic [7:0]  mb;
    logic [7:0]  bv;
    int          nb;
    int          kf;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    a.start      = 1'b0;
    a.match_byte = 8'h00;
    a.in_valid   = 1'b0;
    a.in_data    = 32'h0;
    a.out_ready  = 1'b0;
    tick();
    tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    beats = '{32'h11223344, 32'h00556677};
    run_scan(8'h00, beats, 1'b0, 0);
    beats = '{32'h41424300};
    run_scan(8'h00, beats, 1'b0, 1);
    beats = '{32'h2F002F41};
    run_scan(8'h2F, beats, 1'b0, 5);
    beats = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010100};
    run_scan(8'h00, beats, 1'b1, 2);

    // Reset mid-scan: no result, then a fresh scan counts from zero.
    a.start      = 1'b1;
    a.match_byte = 8'h00;
    tick();
    a.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = 32'h99887766;
      tick();
    end
    a.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset("post_rst");
    beats = '{32'h11111111, 32'h00222222};
    run_scan(8'h00, beats, 1'b0, 0);

    for (int it = 0; it < 30; it++) begin
      mb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      nb = $urandom_range(1, 6);
      kf = $urandom_range(0, 3);
      beats = {};
      for (int i = 0; i < nb; i++) begin
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
          bv = 8'($urandom);
          if (bv == mb) bv = bv ^ 8'h01;
          if ($urandom_range(0, 11) == 0) bv = mb;
          if (i == nb - 1 && k == kf) bv = mb;
          w[8*k +: 8] = bv;
        end
        beats.push_back(w);
      end
      run_scan(mb, beats, 1'b1, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
